// File: rtl/main_control_if.sv
// main_control_if: opcode/flag inputs and datapath control outputs of the multicycle RV32 controller
interface main_control_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       reg_write;
  logic       mem_write;
  logic       illegal_instr;
  logic [3:0] state;
  modport master (
    input  op, zero, mem_ready,
    output alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_instr, state
  );
  modport slave (
    output op, zero, mem_ready,
    input  alu_op, alu_src_a, alu_src_b, result_src, adr_src,
           ir_write, pc_write, reg_write, mem_write, illegal_instr, state
  );
endinterface

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle RV32 main controller (lw, sw, R, I, beq, jal; other opcodes trap)
module main_control_fsm #(
  parameter bit MEM_WAIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  main_control_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3,
    MEMWB = 4'd4, MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7,
    ALUWB = 4'd8, BEQ = 4'd9, JAL = 4'd10, TRAP = 4'd11
  } state_t;
  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   rdy, pc_update, branch, ir_en, reg_en, mem_en;
  assign rdy = MEM_WAIT ? bus.mem_ready : 1'b1;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    state_d = rdy ? DECODE : FETCH;
      DECODE:   case (bus.op)
                  7'b0000011, 7'b0100011: state_d = MEMADR;
                  7'b0110011:             state_d = EXECR;
                  7'b0010011:             state_d = EXECI;
                  7'b1100011:             state_d = BEQ;
                  7'b1101111:             state_d = JAL;
                  default:                state_d = TRAP;
                endcase
      MEMADR:   state_d = (bus.op == 7'b0000011) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_d = rdy ? MEMWB : MEMREAD;
      MEMWRITE: state_d = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: state_d = ALUWB;
      MEMWB, ALUWB, BEQ: state_d = FETCH;
      default:  state_d = TRAP;
    endcase
    illegal_d = illegal_q | (state_d == TRAP);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    bus.alu_op     = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.result_src = 2'b00;
    bus.adr_src    = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    ir_en          = 1'b0;
    reg_en         = 1'b0;
    mem_en         = 1'b0;
    case (state_q)
      FETCH:    begin bus.alu_src_b = 2'b10; bus.result_src = 2'b10; ir_en = rdy; pc_update = rdy; end
      DECODE:   begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01; end
      MEMADR:   begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; end
      MEMREAD:  bus.adr_src = 1'b1;
      MEMWB:    begin bus.result_src = 2'b01; reg_en = 1'b1; end
      MEMWRITE: begin bus.adr_src = 1'b1; mem_en = 1'b1; end
      EXECR:    begin bus.alu_src_a = 2'b10; bus.alu_op = 2'b10; end
      EXECI:    begin bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; bus.alu_op = 2'b10; end
      ALUWB:    reg_en = 1'b1;
      BEQ:      begin bus.alu_src_a = 2'b10; bus.alu_op = 2'b01; branch = 1'b1; end
      JAL:      begin bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10; pc_update = 1'b1; end
      default:  ;
    endcase
    // strobes are suppressed combinationally while reset is asserted
    bus.ir_write      = rst_n & ir_en;
    bus.pc_write      = rst_n & (pc_update | (branch & bus.zero));
    bus.reg_write     = rst_n & reg_en;
    bus.mem_write     = rst_n & mem_en;
    bus.illegal_instr = illegal_q;
    bus.state         = state_q;
  end
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: cycle-stepped scoreboard check of states and control outputs
module tb_main_control_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   ncyc = 0;
  logic [17:0] exp_q[$];
  main_control_if bus();
  main_control_fsm #(.MEM_WAIT(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask
  // expected {state, alu_op, src_a, src_b, result_src, adr_src, ir, pcw, rw, mw, illegal}
  function automatic logic [17:0] ev(input int s, input bit rdy, input bit z, input bit ill, input bit rl);
    logic [3:0] sv;
    logic [1:0] aop, a, b, rs;
    logic adr, ir, pcw, rw, mw;
    sv = s[3:0];
    {aop, a, b, rs, adr, ir, pcw, rw, mw} = '0;
    case (s)
      0:  begin b = 2'b10; rs = 2'b10; ir = rdy; pcw = rdy; end
      1:  begin a = 2'b01; b = 2'b01; end
      2:  begin a = 2'b10; b = 2'b01; end
      3:  adr = 1'b1;
      4:  begin rs = 2'b01; rw = 1'b1; end
      5:  begin adr = 1'b1; mw = 1'b1; end
      6:  begin a = 2'b10; aop = 2'b10; end
      7:  begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      8:  rw = 1'b1;
      9:  begin a = 2'b10; aop = 2'b01; pcw = z; end
      10: begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (rl) {ir, pcw, rw, mw} = '0;
    return {sv, aop, a, b, rs, adr, ir, pcw, rw, mw, ill};
  endfunction
  task automatic cyc(input int s, input bit rdy = 1, input bit z = 0, input bit ill = 0, input bit rl = 0);
    bus.mem_ready = rdy;
    bus.zero = z;
    exp_q.push_back(ev(s, rdy, z, ill, rl));
    #1;
    chk($sformatf("cyc%0d_s%0d", ncyc, s),
        {14'b0, bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.result_src,
         bus.adr_src, bus.ir_write, bus.pc_write, bus.reg_write, bus.mem_write, bus.illegal_instr},
        {14'b0, exp_q.pop_front()});
    ncyc++;
    @(negedge clk);
  endtask
  initial begin
    bus.op = 7'b0110011;
    bus.mem_ready = 1'b1;
    bus.zero = 1'b0;
    cyc(0, 1, 0, 0, 1);
    cyc(0, 1, 0, 0, 1);
    rst_n = 1'b1;
    cyc(0); cyc(1); cyc(6); cyc(8);
    bus.op = 7'b0000011;
    cyc(0); cyc(1); cyc(2); cyc(3); cyc(4);
    bus.op = 7'b0100011;
    cyc(0); cyc(1); cyc(2); cyc(5, 0); cyc(5, 0); cyc(5, 1);
    bus.op = 7'b0010011;
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1); cyc(1); cyc(7); cyc(8);
    bus.op = 7'b0000011;
    cyc(0); cyc(1); cyc(2); cyc(3, 0); cyc(3, 1); cyc(4);
    bus.op = 7'b1100011;
    cyc(0); cyc(1); cyc(9, 1, 1);
    cyc(0); cyc(1); cyc(9, 1, 0);
    bus.op = 7'b1101111;
    cyc(0); cyc(1); cyc(10); cyc(8);
    bus.op = 7'b0000011;
    cyc(0); cyc(1); cyc(2);
    rst_n = 1'b0;
    cyc(0, 1, 0, 0, 1);
    rst_n = 1'b1;
    bus.op = 7'b0110111;
    cyc(0); cyc(1); cyc(11, 1, 0, 1); cyc(11, 1, 1, 1); cyc(11, 0, 0, 1);
    rst_n = 1'b0;
    cyc(0, 1, 0, 0, 1);
    rst_n = 1'b1;
    bus.op = 7'b0110011;
    cyc(0); cyc(1); cyc(6); cyc(8); cyc(0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
